slice_stream_reader: RTL
========================

Name: slice_stream_reader

Overview:
- Holds an unpacked array of DEPTH elements, loaded in bulk from a flattened bus.
- Streams any contiguous slice [lo:hi] out one element per beat on a valid/ready interface.
- Order is ascending when lo<=hi and descending (reversed) when lo>hi.
- Serves as the read side for blocks that build arrays by slice assignment; consumers can pull sub-ranges or reversed ranges serially.

Parameters:
WIDTH, 8, element width in bits
DEPTH, 10, number of array elements (>=2)
IDX_W, 4, index width; must satisfy 2**IDX_W >= DEPTH

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
load_en  in  1  capture load_data into the array
load_data  in  DEPTH*WIDTH  flattened array; element i = load_data[i*WIDTH +: WIDTH]
load_drop  out  1  one-cycle pulse: load_en arrived while busy and was ignored
req_valid  in  1  slice request valid
req_ready  out  1  request can be accepted
req_lo  in  IDX_W  first index streamed
req_hi  in  IDX_W  last index streamed
out_valid  out  1  out_data/out_idx valid
out_ready  in  1  consumer accepts beat
out_data  out  WIDTH  element value, equals mem[out_idx]
out_idx  out  IDX_W  index of current element
out_last  out  1  current beat is the final element of the slice
err  out  1  one-cycle pulse: accepted request was out of range
busy  out  1  FSM in STREAM

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, cur=0, end=0, dir=up, every mem element=0. Outputs: out_valid=0, out_last=0, out_idx=0, out_data=0, err=0, load_drop=0, busy=0. req_ready=0 while rst is high.
- FSM states: IDLE and STREAM.
- req_ready = (state==IDLE) & ~rst. The request handshake fires on req_valid & req_ready.
- IDLE, range check on accept: if req_lo>=DEPTH or req_hi>=DEPTH, stay in IDLE and drive err=1 in the next cycle only. No beats are produced.
- IDLE, valid accept: set cur=req_lo, end=req_hi, dir=(req_lo<=req_hi ? up : down), go to STREAM. out_valid=1 in the following cycle, so first-beat latency is 1 cycle.
- STREAM outputs: out_valid=1 and busy=1. out_idx=cur. out_data=mem[cur], combinational read of the array, which is frozen while in STREAM. out_last=(cur==end).
- STREAM beat handshake fires on out_valid & out_ready:
  - If out_last: go to IDLE, with req_ready=1 in the next cycle.
  - Otherwise: cur = cur+1 (up) or cur-1 (down).
- Slice length = |hi-lo|+1 beats. lo==hi gives exactly 1 beat with out_last=1.
- Backpressure: while out_valid & ~out_ready, out_idx, out_data and out_last hold stable. No beats are dropped or duplicated.
- load_en in IDLE: mem is written at that edge.
- load_en together with a request accept in the same IDLE cycle: both take effect. The first beat returns the newly loaded data.
- load_en in STREAM: ignored, mem unchanged, load_drop=1 for the next cycle. The stream continues unaffected.
- rst in STREAM: at that edge the stream aborts. out_valid=0 and mem=0 from the next cycle. No out_last is emitted.
- Index arithmetic is IDX_W bits wide. Range-checked bounds guarantee cur never wraps.

Test Plan:
- Ascending slice: load mem[i]=8'hA0+i, request lo=2 hi=5, out_ready=1. Required: out_valid rises 1 cycle after accept; beats A2,A3,A4,A5 with idx 2..5; out_last only on A5; req_ready=1 the cycle after the A5 beat.
- Descending and single-element slices: request lo=9 hi=7 -> A9,A8,A7 with last on A7. Then request lo=hi=4 -> one beat A4 with out_last=1.
- Backpressure: slice lo=0 hi=3; hold out_ready=0 for 3 cycles at beat idx=1. Required: A1 and idx=1 held stable for 4 cycles total; then A2 and A3 follow; exactly 4 beats overall.
- Out of range: request lo=10 hi=2. Required: err=1 for exactly one cycle; out_valid stays 0; busy stays 0; next request is accepted normally.
- Load interactions:
  - load_en with all elements 8'h55 during STREAM of lo=0 hi=2: beats remain A0,A1,A2 and load_drop pulses once.
  - Then load_en with 8'h33 simultaneous with request lo=1 hi=1: beat value is 8'h33.
- Reset mid-stream: assert rst during the second beat of a lo=0 hi=9 slice. Required: out_valid=0 the next cycle; a subsequent request lo=0 hi=0 returns 8'h00.

Source files
------------

// File: rtl/slice_stream_reader.sv
// Array buffer loaded in bulk from a flattened bus. Any contiguous slice streams
// out on a valid/ready port, ascending when lo<=hi and descending otherwise.
module slice_stream_reader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 10,
    parameter int IDX_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_en,
    input  logic [DEPTH*WIDTH-1:0] load_data,
    output logic                   load_drop,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [IDX_W-1:0]       req_lo,
    input  logic [IDX_W-1:0]       req_hi,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   out_last,
    output logic                   err,
    output logic                   busy
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    // One extra bit so DEPTH stays representable when 2**IDX_W == DEPTH.
    localparam logic [IDX_W:0] DEPTH_W = DEPTH[IDX_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [0:0]       state;
    logic [IDX_W-1:0] cur;
    logic [IDX_W-1:0] end_idx;
    logic             dir_down;
    logic             accept;
    logic             out_of_range;
    logic             at_end;

    assign req_ready    = (state == IDLE) & ~rst;
    assign accept       = req_valid & req_ready;
    assign out_of_range = ({1'b0, req_lo} >= DEPTH_W) | ({1'b0, req_hi} >= DEPTH_W);
    assign at_end       = (cur == end_idx);

    assign out_valid = (state == STREAM);
    assign busy      = (state == STREAM);
    assign out_idx   = cur;
    assign out_data  = mem[cur];
    // Gated by state: cur==end_idx also holds in IDLE after reset.
    assign out_last  = (state == STREAM) & at_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= '0;
            end_idx   <= '0;
            dir_down  <= 1'b0;
            err       <= 1'b0;
            load_drop <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            err       <= 1'b0;
            load_drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_en) begin
                        for (int unsigned i = 0; i < DEPTH; i++) begin
                            mem[i] <= load_data[i*WIDTH +: WIDTH];
                        end
                    end
                    if (accept) begin
                        if (out_of_range) begin
                            err <= 1'b1;
                        end else begin
                            cur      <= req_lo;
                            end_idx  <= req_hi;
                            dir_down <= (req_lo > req_hi);
                            state    <= STREAM;
                        end
                    end
                end
                default: begin
                    // The array is frozen while streaming; late loads are reported.
                    if (load_en) begin
                        load_drop <= 1'b1;
                    end
                    if (out_ready) begin
                        if (at_end) begin
                            state <= IDLE;
                        end else if (dir_down) begin
                            cur <= cur - 1'b1;
                        end else begin
                            cur <= cur + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
